// File: rtl/instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue
// Fetch stage of the nRisc core. Owns the fetch address and issues one
// request at a time to instruction memory. Returned instructions are kept,
// with their addresses, in a small circular queue that the decoder drains
// through a valid/ready handshake. A redirect flushes the queue. If a
// request is outstanding when the redirect arrives, the response is drained
// and then dropped (KILL state).
//
// Parameters:
//   DEPTH - queue entries (2 or 4)
//   AW    - address width
//   IW    - instruction width
// Ports:
//   i_clk           clock, all state on posedge
//   i_rst           asynchronous active-high reset
//   i_redirect      load i_redirect_pc as fetch address, flush queue
//   i_redirect_pc   redirect target
//   o_imem_req      fetch request, held until acknowledged
//   o_imem_addr     fetch address, stable while o_imem_req=1
//   i_imem_ack      single-cycle acknowledge, data valid same cycle
//   i_imem_data     fetched instruction
//   o_instr_valid   queue head valid
//   o_instr         instruction at queue head
//   o_instr_pc      address of queue-head instruction
//   i_instr_ready   decoder accepts head when o_instr_valid=1
// ---------------------------------------------------------------------------
module instruction_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 8,
  parameter int IW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_ack,
  input  logic [IW-1:0] i_imem_data,
  output logic          o_instr_valid,
  output logic [IW-1:0] o_instr,
  output logic [AW-1:0] o_instr_pc,
  input  logic          i_instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_fetch_ptr;
  logic [AW-1:0] r_imem_addr;
  logic          r_imem_req;
  logic          r_valid;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_q_pc    [DEPTH];
  logic [IW-1:0] r_q_instr [DEPTH];

  logic [1:0]    w_state_nxt;
  logic [AW-1:0] w_fetch_ptr_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_count_pop;
  logic [CW-1:0] w_count_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_ack;

  // Next-state logic for the fetch FSM, fetch pointer and queue bookkeeping
  always_comb begin
    // A redirect voids any pop in the same cycle.
    w_pop           = (r_count != CNT_ZERO) && i_instr_ready && !i_redirect;
    // Acks are only meaningful while a request is outstanding (REQ or KILL).
    w_ack           = (r_state != S_IDLE) && i_imem_ack;
    w_push          = (r_state == S_REQ) && i_imem_ack && !i_redirect;
    w_count_pop     = r_count - CW'(w_pop);
    w_count_nxt     = w_count_pop + CW'(w_push);
    w_rd_ptr_nxt    = r_rd_ptr + PW'(w_pop);
    w_wr_ptr_nxt    = r_wr_ptr + PW'(w_push);
    w_state_nxt     = r_state;
    w_fetch_ptr_nxt = r_fetch_ptr;
    w_addr_nxt      = r_imem_addr;
    if (i_redirect) begin
      w_fetch_ptr_nxt = i_redirect_pc;
      w_count_nxt     = CNT_ZERO;
      w_rd_ptr_nxt    = PTR_ZERO;
      w_wr_ptr_nxt    = PTR_ZERO;
      case (r_state)
        S_IDLE:         w_state_nxt = S_IDLE;
        // An unacknowledged request must still be drained at the old address.
        S_REQ, S_KILL:  w_state_nxt = w_ack ? S_IDLE : S_KILL;
        default:        w_state_nxt = S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_count_pop < DEPTH_C) begin
            w_state_nxt = S_REQ;
            w_addr_nxt  = r_fetch_ptr;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            w_fetch_ptr_nxt = r_fetch_ptr + AW'(1'b1);
            // Chain straight into the next request while the queue has room.
            if (w_count_nxt < DEPTH_C) begin
              w_state_nxt = S_REQ;
              w_addr_nxt  = r_fetch_ptr + AW'(1'b1);
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_KILL: begin
          if (w_ack) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_KILL;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, queue storage and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_fetch_ptr <= {AW{1'b0}};
      r_imem_addr <= {AW{1'b0}};
      r_imem_req  <= 1'b0;
      r_valid     <= 1'b0;
      r_rd_ptr    <= PTR_ZERO;
      r_wr_ptr    <= PTR_ZERO;
      r_count     <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= {AW{1'b0}};
        r_q_instr[i] <= {IW{1'b0}};
      end
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_ptr <= w_fetch_ptr_nxt;
      r_imem_addr <= w_addr_nxt;
      r_imem_req  <= (w_state_nxt != S_IDLE);
      r_valid     <= (w_count_nxt != CNT_ZERO);
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_count     <= w_count_nxt;
      if (w_push) begin
        r_q_pc[r_wr_ptr]    <= r_imem_addr;
        r_q_instr[r_wr_ptr] <= i_imem_data;
      end
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_imem_addr;
  assign o_instr_valid = r_valid;
  assign o_instr       = r_q_instr[r_rd_ptr];
  assign o_instr_pc    = r_q_pc[r_rd_ptr];

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_queue
// Randomised bench for instruction_fetch_queue (DEPTH=2, AW=IW=8).
// The memory returns addr^0xA5. The reference model tracks the next fetch
// address, the buffered-instruction count and whether a killed request is
// outstanding. Every accepted fetch pushes its expected PC into a scoreboard
// queue, and the decoder-side monitor pops and compares on each handshake.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_queue;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready;

  always #5 clk = ~clk;

  instruction_fetch_queue #(.DEPTH(DEPTH), .AW(8), .IW(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
    .i_imem_data(imem_data), .o_instr_valid(instr_valid), .o_instr(instr),
    .o_instr_pc(instr_pc), .i_instr_ready(instr_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus controls and memory responder ----------------
  int         lat_min = 0, lat_max = 0, rdy_mode = 1, redir_rate = 0;
  bit         spur_en = 1'b0;
  bit         force_redir = 1'b0;
  logic [7:0] force_pc = 8'h00;
  bit         mem_busy = 1'b0;
  int         mem_wait = 0;

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = int'($urandom_range(lat_max, lat_min));
      end
      if (mem_wait == 0) begin
        imem_ack  = 1'b1;
        imem_data = imem_addr ^ 8'hA5;
        mem_busy  = 1'b0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 8'($urandom_range(255, 0));
        mem_wait--;
      end
    end else begin
      // Stray acks without a request must be ignored by the DUT.
      imem_ack  = spur_en && ($urandom_range(5, 0) == 0);
      imem_data = 8'($urandom_range(255, 0));
      mem_busy  = 1'b0;
    end
    if (rdy_mode == 2) instr_ready = 1'($urandom_range(1, 0));
    else               instr_ready = (rdy_mode == 1);
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = force_pc;
      force_redir = 1'b0;
    end else if (redir_rate != 0 && $urandom_range(redir_rate - 1, 0) == 0) begin
      redirect    = 1'b1;
      redirect_pc = ($urandom_range(3, 0) == 0) ? 8'hFE : 8'($urandom_range(255, 0));
    end else begin
      redirect    = 1'b0;
    end
  endtask

  // ---------------- reference model + scoreboard monitor ----------------
  logic [7:0] exp_q[$];
  logic [7:0] m_next_fetch = 8'h00;
  int         m_occ = 0;
  bit         m_stale = 1'b0;
  bit         m_req_chk = 1'b0;
  bit         m_req_exp = 1'b0;
  bit         m_hold = 1'b0;
  logic [7:0] m_hold_addr = 8'h00;
  bit         mon_pop, mon_ack;
  logic [7:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_next_fetch = 8'h00;
      m_occ        = 0;
      m_stale      = 1'b0;
      m_req_chk    = 1'b0;
      m_hold       = 1'b0;
    end else begin
      check("valid_vs_occupancy", 32'(instr_valid), 32'(m_occ != 0));
      if (m_req_chk) begin
        check("imem_req", 32'(imem_req), 32'(m_req_exp));
        if (m_req_exp && !m_stale) check("imem_addr", 32'(imem_addr), 32'(m_next_fetch));
      end
      if (m_hold) check("addr_hold", 32'(imem_addr), 32'(m_hold_addr));

      mon_pop = instr_valid && instr_ready && !redirect;
      if (mon_pop) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("instr_pc", 32'(instr_pc), 32'(mon_e));
          check("instr", 32'(instr), 32'(mon_e ^ 8'hA5));
        end
      end

      mon_ack = imem_req && imem_ack;
      if (redirect) begin
        if (mon_ack && !m_stale) check("ack_addr", 32'(imem_addr), 32'(m_next_fetch));
        exp_q.delete();
        m_occ        = 0;
        m_next_fetch = redirect_pc;
        m_stale      = imem_req && !imem_ack;
        m_req_exp    = m_stale;
      end else begin
        if (mon_pop) m_occ--;
        if (mon_ack) begin
          if (m_stale) begin
            m_stale   = 1'b0;
            m_req_exp = 1'b0;
          end else begin
            check("ack_addr", 32'(imem_addr), 32'(m_next_fetch));
            exp_q.push_back(m_next_fetch);
            m_next_fetch = m_next_fetch + 8'h01;
            m_occ++;
            m_req_exp = (m_occ < DEPTH);
          end
        end else if (imem_req) begin
          m_req_exp = 1'b1;
        end else begin
          m_req_exp = (m_occ < DEPTH);
        end
        check("occupancy_bound", 32'(m_occ <= DEPTH), 32'd1);
      end
      m_req_chk   = 1'b1;
      m_hold      = imem_req && !imem_ack;
      m_hold_addr = imem_addr;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(imem_req),    32'd0);
    check({tag, "_addr"},  32'(imem_addr),   32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, 32'(instr),       32'd0);
    check({tag, "_pc"},    32'(instr_pc),    32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
    imem_ack = 1'b0; imem_data = 8'h00; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // zero-wait streaming
    lat_min = 0; lat_max = 0; rdy_mode = 1;
    repeat (30) drive_cycle();

    // decoder stall fills the queue, then resumes
    rdy_mode = 0;
    repeat (8) drive_cycle();
    rdy_mode = 1;
    repeat (10) drive_cycle();

    // slow memory, redirect to 0x40 in the 2nd wait cycle
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle();
      if (imem_req && mem_busy && mem_wait == 2) found = 1'b1;
    end
    check("kill_setup_reached", 32'(found), 32'd1);
    force_redir = 1'b1; force_pc = 8'h40;
    repeat (20) drive_cycle();

    // ack, redirect to 0x10 and pending pop in the same cycle
    lat_min = 0; lat_max = 0;
    repeat (5) drive_cycle();
    force_redir = 1'b1; force_pc = 8'h10;
    repeat (10) drive_cycle();

    // address wrap
    force_redir = 1'b1; force_pc = 8'hFE;
    repeat (10) drive_cycle();

    // randomised traffic
    lat_min = 0; lat_max = 3; rdy_mode = 2; redir_rate = 16; spur_en = 1'b1;
    repeat (2000) drive_cycle();

    // asynchronous reset while a request is pending and entries are queued
    lat_min = 2; lat_max = 2; rdy_mode = 0; redir_rate = 0; spur_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      drive_cycle();
      if (imem_req && instr_valid) found = 1'b1;
    end
    check("midreq_setup_reached", 32'(found), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    redirect = 1'b0; imem_ack = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lat_min = 0; lat_max = 0; rdy_mode = 1;
    repeat (20) drive_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch stage of the nRisc core: it owns the fetch address, issues one-at-a-time requests to instruction memory, and buffers returned instructions with their addresses in a small queue for the decode stage. It sits between the program-counter/branch logic, which supplies redirect targets, and the decoder, which consumes instructions through a valid/ready handshake. It decouples variable-latency instruction memory from decode stalls and discards in-flight fetches after a redirect.

## Interface
- DEPTH, 2, queue entries; legal values 2 or 4.
- AW, 8, address width.
- IW, 8, instruction width.

- CLOCK  in  1  single clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- REDIRECT  in  1  load REDIRECT_PC as the new fetch address and flush the queue.
- REDIRECT_PC  in  AW  redirect target.
- IMEM_REQ  out  1  fetch request, held until acknowledged.
- IMEM_ADDR  out  AW  fetch address, stable while IMEM_REQ=1.
- IMEM_ACK  in  1  single-cycle acknowledge; IMEM_DATA is valid in the same cycle.
- IMEM_DATA  in  IW  fetched instruction.
- INSTR_VALID  out  1  queue head is valid.
- INSTR  out  IW  instruction at queue head.
- INSTR_PC  out  AW  address of the queue-head instruction.
- INSTR_READY  in  1  decoder accepts the head when INSTR_VALID=1.

## Operation
- State: fetch_ptr (AW bits), FSM {IDLE, REQ, KILL}, circular queue of DEPTH entries of {pc, instr}, and count (0..DEPTH).
- Reset: fetch_ptr=0, FSM=IDLE, count=0. All outputs are 0.
- Memory protocol: at most one outstanding request. An asserted IMEM_REQ is never withdrawn before IMEM_ACK. An IMEM_ACK with IMEM_REQ=0 is ignored.
- IDLE: if count<DEPTH (after this cycle's pop) and REDIRECT=0, go to REQ with IMEM_ADDR=fetch_ptr.
- REQ: hold IMEM_ADDR. On IMEM_ACK:
  - push {IMEM_ADDR, IMEM_DATA};
  - fetch_ptr = fetch_ptr+1 (mod 2^AW; 0xFF wraps to 0x00);
  - if space remains after the push and pop, stay in REQ with the new address (back-to-back); else go to IDLE.
- Space at ACK time is guaranteed because requests are issued only when count<DEPTH, and count cannot grow while a request is pending. A push to a full queue cannot occur.
- Pop: INSTR_VALID&&INSTR_READY removes the head. Push and pop may occur in the same cycle; count is unchanged.
- REDIRECT (any state):
  - flush the queue (count=0) and set fetch_ptr=REDIRECT_PC;
  - a pop in the same cycle is void;
  - from IDLE, go to IDLE; the request issues next cycle;
  - from REQ without ACK, go to KILL;
  - from REQ with ACK in the same cycle, discard the data and go to IDLE.
- KILL: keep IMEM_REQ=1 with the old address until IMEM_ACK, discard that data, then go to IDLE. A further REDIRECT in KILL only updates fetch_ptr.
- Queue, fetch_ptr and count use modular arithmetic. Queue pointers are log2(DEPTH) bits.

## Timing
- Reset is asynchronous: asserting RESET clears all state and outputs immediately, including mid-request. The memory must tolerate the dropped request.
- First IMEM_REQ rises on the first posedge after RESET deasserts (IDLE→REQ).
- Zero-wait memory (ACK in the same cycle as REQ): one instruction enters the queue per cycle, and IMEM_ADDR increments each cycle.
- Fetch latency: INSTR_VALID rises the cycle after the posedge that samples IMEM_ACK.
- INSTR, INSTR_PC and INSTR_VALID are registered and hold stable while INSTR_VALID=1 and INSTR_READY=0.
- REDIRECT clears INSTR_VALID on the next posedge.
- The first new-target request is issued one cycle after the redirect edge from IDLE, or one cycle after the killed ACK.

## Test plan
- Reset, then zero-wait memory (IMEM_DATA=addr^0xA5), INSTR_READY=1 -> IMEM_ADDR 0x00,0x01,0x02… on consecutive cycles; INSTR_PC/INSTR=0x00/0xA5, 0x01/0xA4… with no gaps.
- INSTR_READY=0 with DEPTH=2 -> exactly 2 pushes (PC 0x00, 0x01), then IMEM_REQ=0. Raising INSTR_READY resumes fetch at 0x02 with no loss or duplication.
- Memory ACK delayed 3 cycles, REDIRECT to 0x40 in the 2nd wait cycle -> IMEM_ADDR held at the old value until ACK; that data never appears; next request is 0x40; INSTR_PC=0x40 first.
- IMEM_ACK and REDIRECT(0x10) in the same cycle with a pop pending -> acked data dropped, count=0, next IMEM_ADDR=0x10.
- REDIRECT to 0xFE, free-running -> INSTR_PC sequence 0xFE, 0xFF, 0x00, 0x01.
- RESET asserted mid-REQ with 2 entries queued -> all outputs 0 immediately; after release, fetch restarts at 0x00.
